lsu_ctrl: RTL

Load/store controller: initiator side of the word-indexed data memory port (mem_we / mem_addr / mem_wd out, mem_rd in).
- Accepts byte-addressed load/store requests from the CPU datapath over a valid/ready handshake.
- Converts byte addresses to word indices; performs byte/halfword stores as read-modify-write; extracts and extends sub-word loads.
- Returns results with a valid/ready response handshake; rejects misaligned or out-of-range accesses with an error code.

---
 rtl/lsu_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller driving a word-indexed data memory port; sub-word stores use read-modify-write.
// Optional LSU_STATS_EN adds saturating load/store/error response counters.
module lsu_ctrl #(
  parameter int          DEPTH    = 100,
  parameter logic [31:0] ERR_CODE = 32'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      state_reg, state_next;
  logic [1:0]  size_reg;
  logic [1:0]  lo_reg;
  logic        signed_reg;
  logic [15:0] wdata_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wd_reg;

  logic        accept;
  logic        req_bad;
  logic [31:0] req_index;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [3:0]  lane_sel;
  logic [31:0] merged;

  assign req_ready  = (state_reg == S_IDLE);
  assign resp_valid = (state_reg == S_RESP);
  assign accept     = req_valid & req_ready;
  assign req_index  = {2'b00, req_addr[31:2]};
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wd     = mem_wd_reg;
  // Gate with rst so a write already in WRITE is dropped in the reset cycle.
  assign mem_we     = (state_reg == S_WRITE) & ~rst;

  always_comb begin
    req_bad = 1'b0;
    if (req_size == SZ_ILL)                              req_bad = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])            req_bad = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_bad = 1'b1;
    if (req_index >= 32'(DEPTH))                         req_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad)                  state_next = S_RESP;
          else if (!req_we)             state_next = S_LOAD;
          else if (req_size == SZ_WORD) state_next = S_WRITE;
          else                          state_next = S_RMW_RD;
        end
      end
      S_LOAD:   state_next = S_RESP;
      S_RMW_RD: state_next = S_WRITE;
      S_WRITE:  state_next = S_RESP;
      S_RESP:   if (resp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Little-endian lane extraction for loads.
  always_comb begin
    ld_byte = mem_rd[7:0];
    case (lo_reg)
      2'd1:    ld_byte = mem_rd[15:8];
      2'd2:    ld_byte = mem_rd[23:16];
      2'd3:    ld_byte = mem_rd[31:24];
      default: ld_byte = mem_rd[7:0];
    endcase
    ld_half = lo_reg[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_reg)
      SZ_BYTE: load_data = {{24{signed_reg & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = {{16{signed_reg & ld_half[15]}}, ld_half};
      default: load_data = mem_rd;
    endcase
  end

  // Replace the addressed lane(s) of the fetched word, keep the others.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_sel[gi] = (size_reg == SZ_HALF) ? (lo_reg[1] == 1'(gi / 2))
                                                  : (lo_reg == 2'(gi));
      assign merged[8*gi +: 8] = lane_sel[gi]
          ? ((size_reg == SZ_HALF) ? wdata_reg[8*(gi % 2) +: 8] : wdata_reg[7:0])
          : mem_rd[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      size_reg       <= SZ_BYTE;
      lo_reg         <= 2'b00;
      signed_reg     <= 1'b0;
      wdata_reg      <= 16'h0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
      mem_addr_reg   <= 32'h0;
      mem_wd_reg     <= 32'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            size_reg   <= req_size;
            lo_reg     <= req_addr[1:0];
            signed_reg <= req_signed;
            wdata_reg  <= req_wdata[15:0];
            if (req_bad) begin
              resp_rdata_reg <= ERR_CODE;
              resp_err_reg   <= 1'b1;
            end else begin
              mem_addr_reg <= req_index;
              if (req_we && (req_size == SZ_WORD)) mem_wd_reg <= req_wdata;
            end
          end
        end
        S_LOAD: begin
          resp_rdata_reg <= load_data;
          resp_err_reg   <= 1'b0;
        end
        S_RMW_RD: mem_wd_reg <= merged;
        S_WRITE: begin
          resp_rdata_reg <= 32'h0;
          resp_err_reg   <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            mem_addr_reg <= 32'h0;
            mem_wd_reg   <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  logic is_load_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_reg <= 1'b0;
      stat_loads  <= 16'h0;
      stat_stores <= 16'h0;
      stat_errs   <= 16'h0;
    end else begin
      if (accept) is_load_reg <= ~req_we;
      if ((state_reg == S_RESP) && resp_ready) begin
        if (resp_err_reg) begin
          if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end else if (is_load_reg) begin
          if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
        end else begin
          if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
        end
      end
    end
  end
`endif

endmodule
